// File: rtl/fir_decim_frac10.sv
// Decimating Q22.10 FIR: keeps the last TAPS samples, emits one filtered sample per DECIM accepted inputs.
// Latency: out_valid rises TAPS+1 cycles after the edge that accepts the DECIM-th sample.
// Backpressure: in_ready is low while filtering or while a result waits for out_ready; out_data holds until taken.
module fir_decim_frac10 #(
    parameter int TAPS  = 20,
    parameter int DECIM = 10,
    parameter int AW    = $clog2(TAPS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          coef_wr,
    input  logic [AW-1:0] coef_addr,
    input  logic [31:0]   coef_data
);

    // IW indexes the tap arrays; TW must also reach TAPS for the drain step.
    localparam int IW = $clog2(TAPS);
    localparam int TW = $clog2(TAPS + 1);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        MAC    = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [31:0] sbuf [TAPS];
    logic signed [31:0] coef [TAPS];
    logic [PW-1:0]      phase;
    logic [TW-1:0]      tap;
    logic signed [31:0] acc;
    logic signed [31:0] prod;
    logic               accept;
    logic               last_phase;
    logic [IW-1:0]      tap_i;
    logic signed [31:0] mac_p;

    // Q22.10 multiply: low 32 bits of the full product, then a shift that rounds toward zero.
    function automatic logic signed [31:0] mul(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [63:0] full;
        logic signed [31:0] p;
        full = a * b;
        p    = full[31:0];
        if (p[31])
            mul = (p + 32'sd1023) >>> 10;
        else
            mul = p >>> 10;
    endfunction

    // The single multiplier reads the tap selected by the MAC counter; the drain step reads tap 0 harmlessly.
    always_comb begin
        tap_i = '0;
        if (tap < TW'(TAPS))
            tap_i = IW'(tap);
        mac_p = mul(coef[tap_i], sbuf[tap_i]);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ACCEPT;
        else
            state <= state_nxt;
    end

    // Next-state decode and input handshake.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last_phase = (phase == PW'(DECIM - 1));
        case (state)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (last_phase)
                        state_nxt = MAC;
                end
            end
            MAC: begin
                if (tap == TW'(TAPS))
                    state_nxt = OUT;
            end
            OUT: begin
                if (out_ready)
                    state_nxt = ACCEPT;
            end
            default: state_nxt = ACCEPT;
        endcase
    end

    // Datapath: sample shift register, coefficient store, decimation phase and the pipelined MAC.
    // The product is registered, so the accumulator trails the tap counter by one cycle and
    // a final drain step folds in the last product as the result is latched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                sbuf[i] <= '0;
                coef[i] <= '0;
            end
            phase     <= '0;
            tap       <= '0;
            acc       <= '0;
            prod      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            // Coefficients only change between filter runs; out-of-range addresses are dropped.
            if (coef_wr && (state == ACCEPT) && (int'(coef_addr) < TAPS))
                coef[IW'(coef_addr)] <= coef_data;

            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--)
                    sbuf[k] <= sbuf[k-1];
                sbuf[0] <= in_data;
                if (last_phase) begin
                    phase <= '0;
                    acc   <= '0;
                    prod  <= '0;
                    tap   <= '0;
                end else begin
                    phase <= phase + PW'(1);
                end
            end

            if (state == MAC) begin
                if (tap < TW'(TAPS)) begin
                    prod <= mac_p;
                    tap  <= tap + TW'(1);
                    if (tap != '0)
                        acc <= acc + prod;
                end else begin
                    out_data  <= acc + prod;
                    out_valid <= 1'b1;
                end
            end

            if ((state == OUT) && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
